// File: rtl/mdu_pkg.sv
// ----------------------------------------------------------------------------
// mdu_pkg : shared op encoding, controller states and constants for the MDU
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package mdu_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5
  } md_op_e;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } md_state_e;

  // Highest op code that occupies the unit for multiple cycles.
  localparam logic [2:0] MD_OP_LAST_LONG = 3'd3;

endpackage

`default_nettype wire

// File: rtl/mdu_arith.sv
// ----------------------------------------------------------------------------
// mdu_arith : combinational multiply/divide datapath (divide only with MDU_DIV_EN)
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module mdu_arith
  import mdu_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [2:0]  op,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo,
  output logic        div0
);

  logic signed [63:0] w_prod_s;
  logic        [63:0] w_prod_u;

  assign w_prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
  assign w_prod_u = {32'd0, a} * {32'd0, b};

`ifdef MDU_DIV_EN
  logic [31:0] w_divisor;
  logic [31:0] w_quot_s;
  logic [31:0] w_rem_s;
  logic [31:0] w_quot_u;
  logic [31:0] w_rem_u;

  assign div0 = (b == 32'd0);
  // Substitute a harmless divisor so a zero divide never produces X.
  assign w_divisor = div0 ? 32'd1 : b;
  assign w_quot_s  = $signed(a) / $signed(w_divisor);
  assign w_rem_s   = $signed(a) % $signed(w_divisor);
  assign w_quot_u  = a / w_divisor;
  assign w_rem_u   = a % w_divisor;
`else
  assign div0 = 1'b0;
`endif

  always_comb begin
    res_hi = 32'd0;
    res_lo = 32'd0;
    case (op)
      OP_MULT:  {res_hi, res_lo} = w_prod_s;
      OP_MULTU: {res_hi, res_lo} = w_prod_u;
`ifdef MDU_DIV_EN
      OP_DIV: begin
        res_hi = w_rem_s;
        res_lo = w_quot_s;
      end
      OP_DIVU: begin
        res_hi = w_rem_u;
        res_lo = w_quot_u;
      end
`endif
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mdu_ctrl.sv
// ----------------------------------------------------------------------------
// mdu_ctrl : HI/LO multiply-divide unit controller; MDU_DIV_EN enables DIV/DIVU
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module mdu_ctrl
  import mdu_pkg::*;
#(
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        use_md,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        stall_req
);

  md_state_e   state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] pend_hi_q, pend_hi_d;
  logic [31:0] pend_lo_q, pend_lo_d;

  logic [31:0] w_res_hi;
  logic [31:0] w_res_lo;
  logic        w_div0;
  logic        w_is_mul;
  logic        w_is_div;

  mdu_arith u_arith (
    .a      (a),
    .b      (b),
    .op     (op),
    .res_hi (w_res_hi),
    .res_lo (w_res_lo),
    .div0   (w_div0)
  );

  assign w_is_mul = (op == OP_MULT) || (op == OP_MULTU);

`ifdef MDU_DIV_EN
  assign w_is_div = (op == OP_DIV) || (op == OP_DIVU);
`else
  logic [3:0] unused_div_cycles;
  assign unused_div_cycles = DIV_CYCLES[3:0];
  assign w_is_div = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (w_is_mul || w_is_div) begin
            // A zero divide re-commits the current HI/LO, leaving them unchanged.
            pend_hi_d = w_div0 ? hi_q : w_res_hi;
            pend_lo_d = w_div0 ? lo_q : w_res_lo;
            cnt_d     = w_is_mul ? 4'(MUL_CYCLES) : 4'(DIV_CYCLES);
            state_d   = RUN;
          end else if (op == OP_MTHI) begin
            hi_d = a;
          end else if (op == OP_MTLO) begin
            lo_d = a;
          end
        end
      end
      RUN: begin
        if (cnt_q <= 4'd1) begin
          cnt_d   = 4'd0;
          hi_d    = pend_hi_q;
          lo_d    = pend_lo_q;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      pend_hi_q <= 32'd0;
      pend_lo_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
    end
  end

  assign hi        = hi_q;
  assign lo        = lo_q;
  assign busy      = (state_q == RUN);
  assign stall_req = use_md & (busy | (start & (op <= MD_OP_LAST_LONG)));

endmodule

`default_nettype wire
